// File: rtl/bcd_bin_32.sv
// -----------------------------------------------------------------------------
// bcd_bin_32
// Sequential packed-BCD to unsigned binary converter, one digit per clock.
// A conversion is captured on a clock edge where start=1 and the block is idle.
// It then runs for N_DIG edges, using a multiply-by-ten accumulate with the
// most significant digit first. When it finishes, valid pulses for one cycle
// and bin/err are updated.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   conversion request, sampled only while busy=0
//   bcd    in   packed BCD word, digit 0 (ones) in bits [3:0]
//   busy   out  conversion in progress
//   bin    out  binary result, held until the next valid pulse
//   valid  out  one-cycle pulse when bin/err are updated
//   err    out  last conversion contained a nibble greater than 9
// -----------------------------------------------------------------------------
module bcd_bin_32 #(
    parameter int N_DIG = 9,
    parameter int BIN_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*N_DIG-1:0]   bcd,
    output logic                 busy,
    output logic [BIN_W-1:0]     bin,
    output logic                 valid,
    output logic                 err
);

    localparam int SH_W  = 4 * N_DIG;
    localparam int CNT_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    // Counter value of the edge that processes the final (least significant) digit.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIG - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [SH_W-1:0]    shreg_r, shreg_s;
    logic [BIN_W-1:0]   acc_r, acc_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               err_sticky_r, err_sticky_s;
    logic [BIN_W-1:0]   bin_r, bin_s;
    logic               err_r, err_s;
    logic               valid_r, valid_s;
    logic               busy_r, busy_s;

    logic [3:0]         digit_s;
    logic               digit_bad_s;
    logic               any_bad_s;
    logic [BIN_W-1:0]   acc_next_s;

    // Next-state and datapath logic for the IDLE/CONV controller.
    always_comb begin
        state_s      = state_r;
        shreg_s      = shreg_r;
        acc_s        = acc_r;
        cnt_s        = cnt_r;
        err_sticky_s = err_sticky_r;
        bin_s        = bin_r;
        err_s        = err_r;
        valid_s      = 1'b0;

        // The digit under conversion is always the top nibble; the register shifts left.
        digit_s     = shreg_r[SH_W-1 -: 4];
        digit_bad_s = (digit_s > 4'd9);
        any_bad_s   = err_sticky_r | digit_bad_s;
        // acc*10 built from two shifts; wraps modulo 2^BIN_W.
        acc_next_s  = (acc_r << 3) + (acc_r << 1) + {{(BIN_W-4){1'b0}}, digit_s};

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    shreg_s      = bcd;
                    acc_s        = {BIN_W{1'b0}};
                    cnt_s        = {CNT_W{1'b0}};
                    err_sticky_s = 1'b0;
                    state_s      = ST_CONV;
                end else begin
                    state_s      = ST_IDLE;
                end
            end
            ST_CONV: begin
                acc_s        = acc_next_s;
                shreg_s      = shreg_r << 4;
                cnt_s        = cnt_r + CNT_W'(1);
                err_sticky_s = any_bad_s;
                if (cnt_r == LAST_CNT) begin
                    // A bad nibble anywhere forces the published result to zero.
                    bin_s   = any_bad_s ? {BIN_W{1'b0}} : acc_next_s;
                    err_s   = any_bad_s;
                    valid_s = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_CONV;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s == ST_CONV);
    end

    // State, datapath and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            shreg_r      <= {SH_W{1'b0}};
            acc_r        <= {BIN_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            err_sticky_r <= 1'b0;
            bin_r        <= {BIN_W{1'b0}};
            err_r        <= 1'b0;
            valid_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            shreg_r      <= shreg_s;
            acc_r        <= acc_s;
            cnt_r        <= cnt_s;
            err_sticky_r <= err_sticky_s;
            bin_r        <= bin_s;
            err_r        <= err_s;
            valid_r      <= valid_s;
            busy_r       <= busy_s;
        end
    end

    assign busy  = busy_r;
    assign bin   = bin_r;
    assign valid = valid_r;
    assign err   = err_r;

endmodule

// File: tb/tb_bcd_bin_32.sv
// -----------------------------------------------------------------------------
// tb_bcd_bin_32
// Scoreboard bench for bcd_bin_32. A reference process sees every accepted
// start, works out the decimal value of the captured word arithmetically, and
// queues it together with the cycle on which valid must appear. A monitor on
// the falling edge pops the queue on each valid and checks bin, err and
// timing. It also checks busy against the reference and checks that bin and
// err hold between results.
// -----------------------------------------------------------------------------
module tb_bcd_bin_32;

    localparam int N_DIG = 9;
    localparam int BIN_W = 32;

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic             err;
        int               due;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [4*N_DIG-1:0]  bcd;
    logic                busy;
    logic [BIN_W-1:0]    bin;
    logic                valid;
    logic                err;

    exp_t                exp_q[$];
    int                  n_vec;
    int                  n_bad;
    int                  cyc;
    int                  m_left;
    logic [BIN_W-1:0]    last_bin;
    logic                last_err;

    bcd_bin_32 #(.N_DIG(N_DIG), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bcd   (bcd),
        .busy  (busy),
        .bin   (bin),
        .valid (valid),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: decimal value as sum of digit * 10^position.
    function automatic exp_t ref_conv(input logic [4*N_DIG-1:0] w, input int due);
        exp_t       e;
        longint     v;
        longint     p;
        bit         bad;
        logic [3:0] nib;
        v   = 0;
        p   = 1;
        bad = 1'b0;
        for (int i = 0; i < N_DIG; i++) begin
            nib = w[4*i +: 4];
            if (nib > 4'd9) bad = 1'b1;
            v = v + longint'(nib) * p;
            p = p * 10;
        end
        e.bin = bad ? '0 : v[BIN_W-1:0];
        e.err = bad;
        e.due = due;
        return e;
    endfunction

    // Reference timing: a start is accepted whenever no conversion is pending.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left   = 0;
            exp_q.delete();
            last_bin = '0;
            last_err = 1'b0;
        end else begin
            cyc = cyc + 1;
            if (m_left > 0) begin
                m_left = m_left - 1;
            end else if (start === 1'b1) begin
                exp_q.push_back(ref_conv(bcd, cyc + N_DIG));
                m_left = N_DIG;
            end
        end
    end

    // Monitor: compares outputs on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("rst_busy",  {63'd0, busy},  64'd0);
            chk("rst_valid", {63'd0, valid}, 64'd0);
            chk("rst_bin",   {32'd0, bin},   64'd0);
            chk("rst_err",   {63'd0, err},   64'd0);
        end else begin
            chk("busy", {63'd0, busy}, {63'd0, (m_left != 0)});
            if (valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", {63'd0, valid}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("bin",   {32'd0, bin},   {32'd0, e.bin});
                    chk("err",   {63'd0, err},   {63'd0, e.err});
                    chk("latency", 64'(cyc), 64'(e.due));
                    last_bin = e.bin;
                    last_err = e.err;
                end
            end else begin
                chk("bin_hold", {32'd0, bin}, {32'd0, last_bin});
                chk("err_hold", {63'd0, err}, {63'd0, last_err});
                if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
                    chk("missing_valid", 64'(cyc), 64'(exp_q[0].due));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic start_one(input logic [4*N_DIG-1:0] w);
        @(negedge clk);
        bcd   = w;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_left != 0 || exp_q.size() != 0) && n < 4 * N_DIG + 10) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (m_left != 0 || exp_q.size() != 0)
            chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [4*N_DIG-1:0] rand_legal();
        logic [4*N_DIG-1:0] w;
        for (int i = 0; i < N_DIG; i++) w[4*i +: 4] = 4'($urandom_range(9, 0));
        return w;
    endfunction

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        cyc      = 0;
        m_left   = 0;
        last_bin = '0;
        last_err = 1'b0;
        rst_n    = 1'b0;
        start    = 1'b0;
        bcd      = '0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Basic and extreme values.
        start_one(36'h123456789); wait_idle();
        chk("basic_bin", {32'd0, bin}, 64'h075BCD15);
        start_one(36'h999999999); wait_idle();
        chk("max_bin", {32'd0, bin}, 64'h3B9AC9FF);
        start_one(36'h000000000); wait_idle();
        start_one(36'h000000001); wait_idle();

        // Invalid digit, then a good one clears err.
        start_one(36'h00000A001); wait_idle();
        chk("bad_err", {63'd0, err}, 64'd1);
        start_one(36'h000000042); wait_idle();
        chk("good_bin", {32'd0, bin}, 64'd42);

        // Start re-pulsed mid-conversion with different data is ignored.
        start_one(36'h000777777);
        @(negedge clk); bcd = 36'h111111111; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); bcd = 36'h222222222; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_idle();
        chk("ignore_bin", {32'd0, bin}, 64'd777777);

        // Start held high for 40 cycles, data (including bad nibbles) changing every cycle.
        @(negedge clk);
        start = 1'b1;
        repeat (40) begin
            bcd = ($urandom_range(3, 0) == 0) ? {$urandom, 4'($urandom)} : rand_legal();
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        // Known result before the reset abort, so clearing bin is visible.
        start_one(36'h000000042); wait_idle();
        start_one(36'h555555555);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", {63'd0, busy}, 64'd0);
        chk("async_bin",  {32'd0, bin},  64'd0);
        chk("async_err",  {63'd0, err},  64'd0);
        chk("async_valid", {63'd0, valid}, 64'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2 * N_DIG) @(negedge clk);
        start_one(36'h000065536); wait_idle();
        chk("post_rst_bin", {32'd0, bin}, 64'd65536);

        // 1000 random legal words back-to-back (one capture per N_DIG+1 clocks).
        @(negedge clk);
        start = 1'b1;
        repeat (1000 * (N_DIG + 1)) begin
            bcd = rand_legal();
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_bin_32.md
Name: bcd_bin_32

Overview:
Sequential BCD-to-binary converter: accepts a packed N_DIG-digit BCD word and returns its unsigned binary value, one digit per clock.
Used where keypad/OLED-entered decimal set-points must become binary for the counter and DDS logic of the frequency meter / waveform generator.
Start/busy/valid handshake; flags non-decimal input nibbles.

Parameters:
N_DIG, 9, number of BCD digits in the input word (digit 0 = ones, in bits [3:0]).
BIN_W, 32, output binary width; defaults satisfy 10^N_DIG-1 < 2^BIN_W, so no overflow is possible.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  conversion request; sampled only while busy=0.
bcd  input  4*N_DIG  packed BCD; bits [4*N_DIG-1:4*N_DIG-4] = most significant digit.
busy  output  1  high while a conversion is in progress.
bin  output  BIN_W  binary result; holds the last result until the next valid.
valid  output  1  one-cycle pulse: bin/err updated.
err  output  1  1 = last conversion contained a nibble > 9; holds with bin.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, valid=0, err=0, bin=0, internal shift register, accumulator, digit counter and error sticky all cleared.
- Reset asserted mid-conversion aborts the conversion. No valid is produced. Outputs take their reset values immediately.
- States: IDLE, CONV.
- IDLE:
  - busy=0.
  - On an edge with start=1: capture bcd into the shift register, acc=0, cnt=0, err_sticky=0, go to CONV.
  - The capture edge is E0.
- CONV:
  - busy=1.
  - Each edge: d = top nibble of the shift register; acc <= acc*10 + d; shift register <<= 4; cnt++.
  - If d > 9, set err_sticky.
  - Implement acc*10 as (acc<<3)+(acc<<1). Arithmetic is modulo 2^BIN_W, so truncation applies only if the parameters violate the rule above.
- Completion:
  - On the edge processing digit N_DIG (E_N_DIG, i.e. E9 by default), the following happen together:
    - bin <= final acc, or 0 if any nibble was > 9.
    - err <= err_sticky (including the current digit).
    - valid <= 1 for exactly one cycle.
    - State returns to IDLE and busy deasserts.
  - Latency: valid is high in the cycle after E_N_DIG, i.e. N_DIG clocks after the start-capture edge.
- start while busy=1 is ignored; no queuing.
- start held high continuously: a new conversion is captured on the first edge with busy=0. That edge is the one at which valid is high, so throughput is one conversion per N_DIG+1 clocks.
- The bcd input may change freely after E0; only the captured copy is used.
- bin and err change only when valid pulses, or on reset.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Basic: bcd=36'h123456789, start pulse 1 cycle → busy high for 9 cycles; valid 9 clks after capture edge; bin=32'd123456789 (0x075BCD15); err=0.
- Extremes: bcd=36'h999999999 → bin=0x3B9AC9FF, err=0. Then bcd=36'h000000000 → bin=0, err=0. Then bcd=36'h000000001 → bin=1.
- Invalid digit: bcd=36'h00000A001 → valid pulses with err=1, bin=0. A following bcd=36'h000000042 → err=0, bin=42.
- Handshake: start re-pulsed at cycles 2 and 5 of a conversion, with bcd changed → ignored; result reflects the first capture only, exactly one valid. start held high for 40 cycles → a valid every 10 clocks with correct results.
- Reset mid-operation: assert rst_n=0 at conversion cycle 4 → busy, valid, err, bin go to 0 immediately, no valid afterward. After release, a new start with 36'h000065536 → bin=65536.
- Random: 1000 random legal 9-digit BCD inputs, back-to-back → bin equals the decimal value of every input.
